// File: rtl/marauder_pkg.sv
// Shared constants for the multi-port ALU register file: write-port indices and default geometry.
package marauder_pkg;

    localparam int NUM_WR         = 2;
    localparam int WP_ALU         = 0;
    localparam int WP_LOAD        = 1;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 8;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: selects write-bypass data over stored data (load beats ALU) and masks busy on a load hit.
module regfile_bypass_mux
    import marauder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [NUM_WR-1:0] wr_ok_i,
    input  logic [ADDR_W-1:0] wr_addr_alu_i,
    input  logic [ADDR_W-1:0] wr_addr_load_i,
    input  logic [DATA_W-1:0] wr_data_alu_i,
    input  logic [DATA_W-1:0] wr_data_load_i,
    input  logic [DATA_W-1:0] stored_data_i,
    input  logic              stored_busy_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    logic hit_alu;
    logic hit_load;

    // wr_ok_i is already qualified for range and the zero register, so no hit can occur there.
    assign hit_alu  = wr_ok_i[WP_ALU]  && (wr_addr_alu_i  == rd_addr_i);
    assign hit_load = wr_ok_i[WP_LOAD] && (wr_addr_load_i == rd_addr_i);

    always_comb begin
        rd_data_o = stored_data_i;
        if (hit_load) begin
            rd_data_o = wr_data_load_i;
        end else if (hit_alu) begin
            rd_data_o = wr_data_alu_i;
        end
    end

    assign rd_busy_o = stored_busy_i && !hit_load;

endmodule

// File: rtl/alu_regfile_mp.sv
// Multi-port register file with ALU/load writeback, same-cycle bypass, optional zero register and load scoreboard.
module alu_regfile_mp
    import marauder_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int NSLOT   = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    output logic                     waw_err
);

    // Storage spans every encodable address; slots at or above DEPTH are never written and stay 0.
    logic [DATA_W-1:0] mem_q [NSLOT];
    logic [DATA_W-1:0] mem_d [NSLOT];
    logic [NSLOT-1:0]  busy_q;
    logic [NSLOT-1:0]  busy_d;
    logic              waw_q;
    logic              waw_d;

    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;
    logic              mark_ok;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wa[p]    = wr_addr[p*ADDR_W +: ADDR_W];
            wd[p]    = wr_data[p*DATA_W +: DATA_W];
            wr_ok[p] = wr_en[p] && addr_ok(wa[p]);
        end
        mark_ok = mark_en && addr_ok(mark_addr);
    end

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int r = 0; r < NSLOT; r++) begin
            if (wr_ok[WP_LOAD] && (wa[WP_LOAD] == ADDR_W'(r))) begin
                mem_d[r]  = wd[WP_LOAD];
                busy_d[r] = 1'b0;
            end else if (wr_ok[WP_ALU] && (wa[WP_ALU] == ADDR_W'(r))) begin
                mem_d[r] = wd[WP_ALU];
            end
            // A new load issued to the same register supersedes the one completing now.
            if (mark_ok && (mark_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        waw_d = wr_ok[WP_ALU] && busy_q[wa[WP_ALU]]
                && !(wr_ok[WP_LOAD] && (wa[WP_LOAD] == wa[WP_ALU]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NSLOT; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    assign waw_err = waw_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        regfile_bypass_mux #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_mux (
            .rd_addr_i      (ra),
            .wr_ok_i        (wr_ok),
            .wr_addr_alu_i  (wa[WP_ALU]),
            .wr_addr_load_i (wa[WP_LOAD]),
            .wr_data_alu_i  (wd[WP_ALU]),
            .wr_data_load_i (wd[WP_LOAD]),
            .stored_data_i  (mem_q[ra]),
            .stored_busy_i  (busy_q[ra]),
            .rd_data_o      (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy_o      (rd_busy[i])
        );
    end

endmodule
